fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_i  input  1  IF/ID stall; output instruction not consumed this cycle.
REQ-005 flush_i  input  1  pipeline flush (exception/ertn).
REQ-006 flush_pc_i  input  32  flush redirect target.
REQ-007 branch_flag_i  input  1  branch taken, resolved in ID/EX.
REQ-008 branch_pc_i  input  32  branch target.
REQ-009 icache_req_o  output  1  fetch request valid.
REQ-010 icache_addr_o  output  32  fetch address, word-aligned.
REQ-011 icache_ready_i  input  1  icache accepts request when high with icache_req_o.
REQ-012 icache_rvalid_i  input  1  response valid, one cycle per accepted request.
REQ-013 icache_rdata_i  input  32  instruction word.
REQ-014 if_pc_o  output  32  PC of delivered instruction, registered.
REQ-015 if_inst_o  output  32  delivered instruction, registered.
REQ-016 if_inst_valid_o  output  1  delivered instruction valid, registered.

Function
REQ-017 FSM states: REQ (request pending), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-018 At most one outstanding icache request at any time.
REQ-019 REQ: icache_req_o=1 only when output buffer empty or consumed this cycle (if_inst_valid_o & !stall_i); icache_addr_o=fetch_pc.
REQ-020 REQ->WAIT on icache_req_o & icache_ready_i.
REQ-021 WAIT, icache_rvalid_i: if_inst_o<=rdata, if_pc_o<=fetch_pc, if_inst_valid_o<=1, fetch_pc<=fetch_pc+4 (mod 2^32 wrap), ->REQ.
REQ-022 Instruction consumed on any cycle with if_inst_valid_o & !stall_i; valid clears next cycle unless REQ-021 reloads the buffer in the same cycle.
REQ-023 While stall_i, if_pc_o/if_inst_o/if_inst_valid_o hold.
REQ-024 Redirect = flush_i or branch_flag_i; target = flush_pc_i if flush_i else branch_pc_i (flush wins).
REQ-025 On redirect: fetch_pc<=target, if_inst_valid_o<=0 regardless of stall_i, outputs zeroed.
REQ-026 Redirect in REQ with request accepted same cycle, or in WAIT without rvalid: ->DROP.
REQ-027 Redirect in WAIT with rvalid same cycle: response discarded, ->REQ.
REQ-028 Redirect in REQ without acceptance: ->REQ, new target issued next cycle.
REQ-029 DROP: icache_req_o=0; on icache_rvalid_i response discarded, ->REQ; further redirect in DROP updates fetch_pc only.
REQ-030 Response latency unconstrained; minimum request-to-output 2 cycles (accept, rvalid, output valid next edge).

Reset
REQ-031 rst overrides all inputs: state<=REQ, fetch_pc<=RESET_PC, if_pc_o<=0, if_inst_o<=0, if_inst_valid_o<=0.
REQ-032 Reset mid-transaction abandons outstanding request; icache is reset concurrently, so no drop is performed.
REQ-033 First icache_req_o asserts in first cycle after rst deasserts.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN: when defined, adds outputs perf_redirect_cnt_o[31:0] (redirects) and perf_drop_cnt_o[31:0] (discarded responses), reset 0, wrapping; when undefined, ports and counters absent, behaviour otherwise identical.

Structure
REQ-035 State encoding enum and RESET_PC default value live in shared defines package.
REQ-036 Single module; no sub-module.

Verification
REQ-037 Reset release, ready=1, rvalid 1 cycle after accept, rdata=32'h02800000 -> addr 1c000000, then if_pc_o=1c000000, valid=1; next addr 1c000004.
REQ-038 Output valid, stall_i high 3 cycles -> outputs stable 3 cycles, icache_req_o=0; stall drop -> next request issues same cycle.
REQ-039 Branch to 1c000100 while WAIT, rvalid 2 cycles later -> response dropped, valid stays 0, next addr 1c000100.
REQ-040 flush_i (1c008000) and branch_flag_i (1c000100) same cycle -> next addr 1c008000.
REQ-041 rst asserted in WAIT, late rvalid ignored -> outputs 0, addr 1c000000.
REQ-042 fetch_pc=32'hfffffffc delivered -> next addr 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// reset fetch address and the registered IF output buffer layout.
package fetch_ctrl_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h1c000000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_buf_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side icache request/response channel; master = fetch controller,
// slave = icache.
interface fetch_ctrl_if;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_ready_i;
  logic        icache_rvalid_i;
  logic [31:0] icache_rdata_i;

  modport master (
    output icache_req_o, icache_addr_o,
    input  icache_ready_i, icache_rvalid_i, icache_rdata_i
  );

  modport slave (
    input  icache_req_o, icache_addr_o,
    output icache_ready_i, icache_rvalid_i, icache_rdata_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding icache request, redirect
// handling with response drop. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [31:0]        flush_pc_i,
  input  logic               branch_flag_i,
  input  logic [31:0]        branch_pc_i,
  fetch_ctrl_if.master       icache,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_inst_o,
  output logic               if_inst_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_redirect_cnt_o,
  output logic [31:0]        perf_drop_cnt_o
`endif
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  if_buf_t      buf_q;

  logic        buf_free, consume, redirect, accept, resp;
  logic [31:0] target;

  assign consume  = buf_q.valid & ~stall_i;
  assign buf_free = ~buf_q.valid | ~stall_i;
  assign redirect = flush_i | branch_flag_i;
  assign target   = flush_i ? flush_pc_i : branch_pc_i;

  // The request must depend on this cycle's stall so a released stall
  // issues the next fetch without a bubble.
  assign icache.icache_req_o  = (state == ST_REQ) & buf_free;
  assign icache.icache_addr_o = fetch_pc;

  assign accept = icache.icache_req_o & icache.icache_ready_i;
  assign resp   = (state == ST_WAIT) & icache.icache_rvalid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
      buf_q    <= '0;
    end else begin
      unique case (state)
        ST_REQ:  if (accept) state <= redirect ? ST_DROP : ST_WAIT;
        ST_WAIT: if (redirect) state <= icache.icache_rvalid_i ? ST_REQ : ST_DROP;
                 else if (icache.icache_rvalid_i) state <= ST_REQ;
        ST_DROP: if (icache.icache_rvalid_i) state <= ST_REQ;
        default: state <= ST_REQ;
      endcase

      if (redirect)  fetch_pc <= target;
      else if (resp) fetch_pc <= seq_pc(fetch_pc);

      // Redirect kills the buffered instruction even while stalled.
      if (redirect)     buf_q       <= '0;
      else if (resp)    buf_q       <= '{valid: 1'b1, pc: fetch_pc, inst: icache.icache_rdata_i};
      else if (consume) buf_q.valid <= 1'b0;
    end
  end

  assign if_pc_o         = buf_q.pc;
  assign if_inst_o       = buf_q.inst;
  assign if_inst_valid_o = buf_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic drop_evt;
  assign drop_evt = icache.icache_rvalid_i &
                    (((state == ST_WAIT) & redirect) | (state == ST_DROP));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirect_cnt_o <= '0;
      perf_drop_cnt_o     <= '0;
    end else begin
      if (redirect) perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
      if (drop_evt) perf_drop_cnt_o     <= perf_drop_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus reset sequences.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic stall, flush, branch;
  logic [31:0] flush_pc, branch_pc;
  logic [31:0] if_pc, if_inst;
  logic if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redir, perf_drop;
`endif

  int checks = 0;
  int failures = 0;

  fetch_ctrl_if ic();

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .stall_i(stall), .flush_i(flush), .flush_pc_i(flush_pc),
    .branch_flag_i(branch), .branch_pc_i(branch_pc),
    .icache(ic.master),
    .if_pc_o(if_pc), .if_inst_o(if_inst), .if_inst_valid_o(if_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_redirect_cnt_o(perf_redir), .perf_drop_cnt_o(perf_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush;
    logic [31:0] fpc;
    logic        br;
    logic [31:0] bpc;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mk(logic s, logic f, logic [31:0] fp, logic b, logic [31:0] bp,
                              logic rd, logic rv, logic [31:0] dat, logic er,
                              logic [31:0] ea, logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.stall = s; v.flush = f; v.fpc = fp; v.br = b; v.bpc = bp;
    v.rdy = rd; v.rv = rv; v.rdata = dat;
    v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic check_outs(int row, logic er, logic [31:0] ea, logic ev,
                            logic [31:0] ep, logic [31:0] ei);
    chk("icache_req", row, {31'd0, ic.icache_req_o}, {31'd0, er});
    chk("icache_addr", row, ic.icache_addr_o, ea);
    chk("if_valid", row, {31'd0, if_valid}, {31'd0, ev});
    chk("if_pc", row, if_pc, ep);
    chk("if_inst", row, if_inst, ei);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch = 0; flush_pc = '0; branch_pc = '0;
    ic.icache_ready_i = 0; ic.icache_rvalid_i = 0; ic.icache_rdata_i = '0;
  endtask

  initial begin
    //            stall flush fpc           br  bpc           rdy rv rdata         | req addr          v  pc            inst
    tbl[0]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000000, 0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h02800000, 0, 32'h1c000000, 0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000004, 1, 32'h1c000000, 32'h02800000);
    tbl[3]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h11111111, 0, 32'h1c000004, 0, 32'h1c000000, 32'h02800000);
    tbl[4]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000008, 1, 32'h1c000004, 32'h11111111);
    tbl[5]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000008, 1, 32'h1c000004, 32'h11111111);
    tbl[6]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000008, 1, 32'h1c000004, 32'h11111111);
    tbl[7]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000008, 1, 32'h1c000004, 32'h11111111);
    tbl[8]  = mk(0, 0, 32'h0,        1, 32'h1c000100, 1, 0, 32'h0,        0, 32'h1c000008, 0, 32'h1c000004, 32'h11111111);
    tbl[9]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000100, 0, 32'h0,        32'h0);
    tbl[10] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'hdeadbeef, 0, 32'h1c000100, 0, 32'h0,        32'h0);
    tbl[11] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000100, 0, 32'h0,        32'h0);
    tbl[12] = mk(0, 1, 32'h1c008000, 1, 32'h1c000100, 0, 0, 32'h0,        1, 32'h1c000100, 0, 32'h0,        32'h0);
    tbl[13] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c008000, 0, 32'h0,        32'h0);
    tbl[14] = mk(0, 0, 32'h0,        1, 32'hfffffffc, 1, 1, 32'h33333333, 0, 32'h1c008000, 0, 32'h0,        32'h0);
    tbl[15] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hfffffffc, 0, 32'h0,        32'h0);
    tbl[16] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h44444444, 0, 32'hfffffffc, 0, 32'h0,        32'h0);
    tbl[17] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h00000000, 1, 32'hfffffffc, 32'h44444444);
    tbl[18] = mk(0, 0, 32'h0,        1, 32'h1c000200, 1, 0, 32'h0,        1, 32'h00000000, 0, 32'hfffffffc, 32'h44444444);
    tbl[19] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000200, 0, 32'h0,        32'h0);
    tbl[20] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h55555555, 0, 32'h1c000200, 0, 32'h0,        32'h0);
    tbl[21] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000200, 0, 32'h0,        32'h0);
    tbl[22] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h66666666, 0, 32'h1c000200, 0, 32'h0,        32'h0);
    tbl[23] = mk(1, 1, 32'h1c008000, 0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000204, 1, 32'h1c000200, 32'h66666666);
    tbl[24] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c008000, 0, 32'h0,        32'h0);

    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    check_outs(-1, 1'b1, 32'h1c000000, 1'b0, 32'h0, 32'h0);
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      stall = tbl[i].stall; flush = tbl[i].flush; flush_pc = tbl[i].fpc;
      branch = tbl[i].br; branch_pc = tbl[i].bpc;
      ic.icache_ready_i = tbl[i].rdy; ic.icache_rvalid_i = tbl[i].rv;
      ic.icache_rdata_i = tbl[i].rdata;
      #1;
      check_outs(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_pc, tbl[i].e_inst);
      @(negedge clk);
    end

    // Row 24 left a request accepted (WAIT); reset abandons it.
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    ic.icache_rvalid_i = 1; ic.icache_rdata_i = 32'h77777777;
    #1;
    check_outs(100, 1'b1, 32'h1c000000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    ic.icache_rvalid_i = 0;
    #1;
    check_outs(101, 1'b1, 32'h1c000000, 1'b0, 32'h0, 32'h0);

    // Reset while a valid instruction is stalled in the buffer.
    ic.icache_ready_i = 1;
    @(negedge clk);
    ic.icache_ready_i = 0; ic.icache_rvalid_i = 1; ic.icache_rdata_i = 32'h88888888;
    @(negedge clk);
    ic.icache_rvalid_i = 0; stall = 1;
    #1;
    check_outs(102, 1'b0, 32'h1c000004, 1'b1, 32'h1c000000, 32'h88888888);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check_outs(103, 1'b1, 32'h1c000000, 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
